// File: rtl/tsc_mem_pkg.sv
// rtl/tsc_mem_pkg.sv - shared types and boot image for the TSC instruction memory
package tsc_mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, WAIT_LOW} state_t;

  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_BAD} op_t;

  localparam int BOOT_LEN = 28;

  localparam logic [15:0] BOOT_IMAGE [BOOT_LEN] = '{
    16'h6000, 16'h6101, 16'h6202, 16'h6303, 16'hf01c, 16'hf41c, 16'hf81c,
    16'hfc1c, 16'h4204, 16'h47fc, 16'hf81c, 16'hfc1c, 16'hf6c0, 16'hf180,
    16'hf81c, 16'hfc1c, 16'h9015, 16'hf01c, 16'hf180, 16'hf180, 16'hf180,
    16'h6000, 16'h4000, 16'hfd80, 16'hf01c, 16'hf41c, 16'hf81c, 16'hfc1c
  };

endpackage

// File: rtl/tsc_mem_array.sv
// rtl/tsc_mem_array.sv - word storage with boot preload on reset, sync write, async read
module tsc_mem_array
  import tsc_mem_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int MEMORY_SIZE = 32,
  parameter int AW          = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEMORY_SIZE; i++) begin
        mem[i] <= (i < BOOT_LEN) ? WORD_SIZE'(BOOT_IMAGE[i]) : '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/tsc_inst_memory.sv
// rtl/tsc_inst_memory.sv - TSC memory responder: fixed-latency 4-phase read/write handshake
module tsc_inst_memory
  import tsc_mem_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int MEMORY_SIZE = 32,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 read_m,
  input  logic                 write_m,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 input_ready,
  output logic                 ack_output,
  output logic                 err,
  output logic                 busy
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int AW = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

  state_t               state, state_nx;
  logic [CW-1:0]        cnt;
  op_t                  op_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] data_q;
  logic [WORD_SIZE-1:0] rdata;
  logic                 accept;
  logic                 enter_resp;
  logic                 in_range;
  logic                 we;

  assign accept     = (state == IDLE) && (read_m || write_m);
  assign enter_resp = (state == BUSY) && (cnt == '0);
  assign in_range   = addr_q < WORD_SIZE'(MEMORY_SIZE);
  assign we         = enter_resp && (op_q == OP_WRITE) && in_range;
  assign busy       = (state != IDLE);

  tsc_mem_array #(
    .WORD_SIZE  (WORD_SIZE),
    .MEMORY_SIZE(MEMORY_SIZE),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (we),
    .addr   (addr_q[AW-1:0]),
    .wdata  (data_q),
    .rdata  (rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (read_m || write_m) state_nx = BUSY;
      BUSY:     if (cnt == '0) state_nx = RESP;
      RESP:     state_nx = WAIT_LOW;
      WAIT_LOW: if (!read_m && !write_m) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // cnt holds the BUSY edges still to pass before the response edge,
  // so the response registers load exactly LATENCY edges after acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      op_q        <= OP_READ;
      addr_q      <= '0;
      data_q      <= '0;
      data_out    <= '0;
      input_ready <= 1'b0;
      ack_output  <= 1'b0;
      err         <= 1'b0;
    end else begin
      input_ready <= 1'b0;
      ack_output  <= 1'b0;
      err         <= 1'b0;
      if (accept) begin
        op_q   <= (read_m && write_m) ? OP_BAD : (write_m ? OP_WRITE : OP_READ);
        addr_q <= address;
        data_q <= data_in;
        cnt    <= CW'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (enter_resp) begin
        case (op_q)
          OP_READ: begin
            input_ready <= 1'b1;
            err         <= !in_range;
            data_out    <= in_range ? rdata : '0;
          end
          OP_WRITE: begin
            ack_output <= 1'b1;
            err        <= !in_range;
          end
          default: begin
            input_ready <= 1'b1;
            ack_output  <= 1'b1;
            err         <= 1'b1;
            data_out    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tsc_inst_memory.sv
// tb/tb_tsc_inst_memory.sv - randomized self-checking bench for tsc_inst_memory at LATENCY 1, 2 and 5
module tb_tsc_inst_memory;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        reset_n     [NDUT];
  logic        read_m      [NDUT];
  logic        write_m     [NDUT];
  logic [15:0] address     [NDUT];
  logic [15:0] data_in     [NDUT];
  logic [15:0] data_out    [NDUT];
  logic        input_ready [NDUT];
  logic        ack_output  [NDUT];
  logic        err         [NDUT];
  logic        busy        [NDUT];

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] boot [28];
  logic [15:0] ref_mem [NDUT][32];
  logic [15:0] last_data [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    tsc_inst_memory #(
      .WORD_SIZE  (16),
      .MEMORY_SIZE(32),
      .LATENCY    (g == 0 ? 1 : (g == 1 ? 2 : 5))
    ) dut (
      .clk        (clk),
      .reset_n    (reset_n[g]),
      .read_m     (read_m[g]),
      .write_m    (write_m[g]),
      .address    (address[g]),
      .data_in    (data_in[g]),
      .data_out   (data_out[g]),
      .input_ready(input_ready[g]),
      .ack_output (ack_output[g]),
      .err        (err[g]),
      .busy       (busy[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 5);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 32; i++) ref_mem[d][i] = (i < 28) ? boot[i] : 16'h0000;
    last_data[d] = 16'h0000;
  endtask

  task automatic check_quiet(input int d, input string tag);
    check_eq($sformatf("%s_pulses[%0d]", tag, d),
             {29'b0, input_ready[d], ack_output[d], err[d]}, 32'd0);
  endtask

  // One complete handshake: raise request, expect the response exactly LATENCY
  // edges later, hold the request `hold` extra cycles, then drop it.
  task automatic txn(input int d, input bit rd, input bit wr, input logic [15:0] a,
                     input logic [15:0] wd, input int hold);
    int          cyc;
    bit          oor;
    logic [15:0] exp_d;
    oor = (a >= 16'd32);
    if (rd && wr)  exp_d = 16'h0000;
    else if (rd)   exp_d = oor ? 16'h0000 : ref_mem[d][a[4:0]];
    else begin
      exp_d = last_data[d];
      if (!oor) ref_mem[d][a[4:0]] = wd;
    end
    last_data[d] = exp_d;

    @(negedge clk);
    read_m[d] = rd; write_m[d] = wr; address[d] = a; data_in[d] = wd;
    @(posedge clk);
    #1;
    address[d] = 16'($urandom);
    data_in[d] = 16'($urandom);
    cyc = 0;
    @(negedge clk);
    while (!(input_ready[d] || ack_output[d]) && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check_eq($sformatf("latency[%0d] a=%h", d, a), cyc, lat_of(d));
    check_eq($sformatf("resp[%0d] a=%h", d, a),
             {29'b0, input_ready[d], ack_output[d], err[d]},
             {29'b0, rd, wr, (rd && wr) || oor});
    check_eq($sformatf("data_out[%0d] a=%h", d, a), data_out[d], exp_d);
    check_eq($sformatf("busy_resp[%0d]", d), busy[d], 1'b1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_quiet(d, "held");
      check_eq($sformatf("busy_held[%0d]", d), busy[d], 1'b1);
    end
    read_m[d] = 1'b0; write_m[d] = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (busy[d] && cyc < 20) begin
      check_quiet(d, "drain");
      cyc++;
      @(negedge clk);
    end
    check_eq($sformatf("to_idle[%0d]", d), busy[d], 1'b0);
    check_quiet(d, "idle");
    check_eq($sformatf("data_hold[%0d]", d), data_out[d], exp_d);
  endtask

  task automatic reset_in_busy(input int d, input logic [15:0] a, input logic [15:0] wd);
    @(negedge clk);
    write_m[d] = 1'b1; address[d] = a; data_in[d] = wd;
    @(posedge clk);
    @(negedge clk);
    check_eq($sformatf("busy_pre_rst[%0d]", d), busy[d], 1'b1);
    reset_n[d] = 1'b0;
    #1;
    check_eq($sformatf("rst_async[%0d]", d),
             {data_out[d], input_ready[d], ack_output[d], err[d], busy[d]}, 20'h0);
    write_m[d] = 1'b0;
    model_reset(d);
    @(negedge clk);
    reset_n[d] = 1'b1;
  endtask

  initial begin
    boot = '{16'h6000, 16'h6101, 16'h6202, 16'h6303, 16'hf01c, 16'hf41c, 16'hf81c,
             16'hfc1c, 16'h4204, 16'h47fc, 16'hf81c, 16'hfc1c, 16'hf6c0, 16'hf180,
             16'hf81c, 16'hfc1c, 16'h9015, 16'hf01c, 16'hf180, 16'hf180, 16'hf180,
             16'h6000, 16'h4000, 16'hfd80, 16'hf01c, 16'hf41c, 16'hf81c, 16'hfc1c};
    for (int d = 0; d < NDUT; d++) begin
      reset_n[d] = 1'b0; read_m[d] = 1'b0; write_m[d] = 1'b0;
      address[d] = 16'h0; data_in[d] = 16'h0;
      model_reset(d);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("reset_state[%0d]", d),
               {data_out[d], input_ready[d], ack_output[d], err[d], busy[d]}, 20'h0);
      reset_n[d] = 1'b1;
    end

    for (int d = 0; d < NDUT; d++) begin
      txn(d, 1, 0, 16'd0,  16'h0,    0);
      txn(d, 0, 1, 16'd5,  16'hABCD, 0);
      txn(d, 1, 0, 16'd5,  16'h0,    0);
      txn(d, 1, 0, 16'd28, 16'h0,    1);
      txn(d, 1, 0, 16'd40, 16'h0,    0);
      txn(d, 0, 1, 16'd40, 16'h1234, 0);
      txn(d, 1, 1, 16'd3,  16'h5555, 2);
      txn(d, 1, 0, 16'd3,  16'h0,    0);
      txn(d, 1, 0, 16'd7,  16'h0,    10);
      txn(d, 1, 0, 16'd16, 16'h0,    0);
      for (int n = 0; n < 30; n++) begin
        int          r;
        logic [15:0] a;
        r = $urandom_range(0, 9);
        a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(32, 65535))
                                        : 16'($urandom_range(0, 31));
        txn(d, (r <= 5), (r == 0) || (r >= 6), a, 16'($urandom), $urandom_range(0, 3));
      end
      reset_in_busy(d, 16'd4, 16'h0000);
      txn(d, 1, 0, 16'd4, 16'h0, 0);
      txn(d, 1, 0, 16'd5, 16'h0, 0);
    end

    for (int i = 0; i < 32; i++) txn(1, 1, 0, 16'(i), 16'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
